bin_decode_stream: RTL

Streaming, parametrised binary decoder and successor to the combinational binary-to-one-hot converter. It accepts a binary index and a per-transaction mode over a valid/ready handshake, and returns a registered one-hot, thermometer or inverted one-hot vector with range checking. An internal skid buffer sustains one transaction per cycle under back-pressure, and a saturating error counter records bad requests. It sits between an index-producing stage (arbiter, address slice) and select/enable logic that needs registered, flow-controlled vectors.

---
 rtl/bin_decode_pkg.sv | 37 +++
 rtl/bin_decode_stream_skid_buf.sv | 80 ++++++++
 rtl/bin_decode_stream.sv | 95 +++++++++
 3 files changed

// File: rtl/bin_decode_pkg.sv
// Shared types and the decode helper for the streaming binary decoder.
package bin_decode_pkg;

    // Widest output vector any instance may request.
    localparam int unsigned VEC_MAX_W = 256;

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'b00,
        MODE_THERM  = 2'b01,
        MODE_INV    = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    // Decoded value of output bit idx for index bin in a vector of the
    // given width. Bits at or beyond the width are always clear.
    function automatic logic decode_bit(
        input logic [31:0]  bin,
        input mode_e        mode,
        input int unsigned  idx,
        input int unsigned  width
    );
        logic b;
        b = 1'b0;
        if (idx < width) begin
            case (mode)
                MODE_ONEHOT: b = (idx == bin);
                MODE_THERM:  b = (idx <= bin);
                MODE_INV:    b = (idx != bin);
                default:     b = 1'b0;
            endcase
        end else begin
            b = 1'b0;
        end
        return b;
    endfunction

endpackage

// File: rtl/bin_decode_stream_skid_buf.sv
// Two-entry valid/ready buffer: one output register plus one skid entry.
// in_ready is registered and equals "skid entry empty", so there is no
// combinational path from out_ready to in_ready.
module skid_buf #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         r_out_valid;
    logic [W-1:0] r_out_data;
    logic         r_skid_valid;
    logic [W-1:0] r_skid_data;
    logic         r_ready;

    logic         w_in_fire;
    logic         w_out_fire;
    logic         w_out_valid_nxt;
    logic [W-1:0] w_out_data_nxt;
    logic         w_skid_valid_nxt;
    logic [W-1:0] w_skid_data_nxt;

    // Next-state: refill the output register from skid first, then from input.
    always_comb begin
        w_in_fire        = in_valid && r_ready;
        w_out_fire       = r_out_valid && out_ready;
        w_out_valid_nxt  = r_out_valid;
        w_out_data_nxt   = r_out_data;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        if (!r_out_valid || w_out_fire) begin
            if (r_skid_valid) begin
                w_out_valid_nxt  = 1'b1;
                w_out_data_nxt   = r_skid_data;
                w_skid_valid_nxt = 1'b0;
            end else if (w_in_fire) begin
                w_out_valid_nxt  = 1'b1;
                w_out_data_nxt   = in_data;
            end else begin
                w_out_valid_nxt  = 1'b0;
            end
        end else begin
            if (w_in_fire) begin
                w_skid_valid_nxt = 1'b1;
                w_skid_data_nxt  = in_data;
            end else begin
                w_skid_valid_nxt = r_skid_valid;
            end
        end
    end

    // Storage registers; reset empties both entries and holds off the upstream.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_ready      <= 1'b0;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_out_data   <= w_out_data_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_ready      <= !w_skid_valid_nxt;
        end
    end

    assign in_ready  = r_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: rtl/bin_decode_stream.sv
// Streaming binary decoder: one-hot / thermometer / inverted one-hot with
// range checking, a two-entry output buffer and a saturating error counter.
module bin_decode_stream
    import bin_decode_pkg::*;
#(
    parameter int BIN_W     = 4,
    parameter int ONE_HOT_W = 16,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [BIN_W-1:0]     bin_i,
    input  logic [1:0]           mode_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [ONE_HOT_W-1:0] vec_o,
    output logic                 err_o,
    output logic [CNT_W-1:0]     err_cnt_o
);

    generate
        if (BIN_W < 1 || BIN_W > 8 || ONE_HOT_W < 1 || ONE_HOT_W > (2 ** BIN_W) ||
            ONE_HOT_W > int'(VEC_MAX_W) || CNT_W < 1) begin : g_bad_params
            $error("bin_decode_stream: illegal BIN_W/ONE_HOT_W/CNT_W combination");
        end
    endgenerate

    typedef struct packed {
        logic [ONE_HOT_W-1:0] vec;
        logic                 err;
    } result_t;

    localparam int             RES_W   = $bits(result_t);
    localparam logic [BIN_W:0] LIMIT   = (BIN_W + 1)'(ONE_HOT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             w_ready;
    logic             w_accept;
    logic             w_range_err;
    logic             w_mode_err;
    result_t          w_res;
    result_t          w_out_res;
    logic [RES_W-1:0] w_out_bits;
    logic [CNT_W-1:0] r_err_cnt;

    assign w_accept    = valid_i && w_ready;
    assign w_range_err = ({1'b0, bin_i} >= LIMIT);
    assign w_mode_err  = (mode_i == MODE_RSVD);

    // Decode the request at accept time; errors force an all-zero vector.
    always_comb begin
        w_res     = '0;
        w_res.err = w_range_err || w_mode_err;
        if (w_res.err) begin
            w_res.vec = '0;
        end else begin
            for (int unsigned i = 0; i < ONE_HOT_W; i++) begin
                w_res.vec[i] = decode_bit(32'(bin_i), mode_e'(mode_i), i, ONE_HOT_W);
            end
        end
    end

    // Count accepted error requests, saturating at the all-ones value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_res.err && (r_err_cnt != CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end else begin
            r_err_cnt <= r_err_cnt;
        end
    end

    skid_buf #(
        .W (RES_W)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (valid_i),
        .in_ready  (w_ready),
        .in_data   (w_res),
        .out_valid (valid_o),
        .out_ready (ready_i),
        .out_data  (w_out_bits)
    );

    assign w_out_res = w_out_bits;
    assign ready_o   = w_ready;
    assign vec_o     = w_out_res.vec;
    assign err_o     = w_out_res.err;
    assign err_cnt_o = r_err_cnt;

endmodule
